// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, ALU op and sequencer state types
//
// Purpose: constants and types shared by the calculator sequencer blocks.
// Contents: KEY_* key codes, alu_op_t, state_t, key classification helpers.
package calc_pkg;

   localparam logic [7:0] KEY_ADD = 8'h0A;
   localparam logic [7:0] KEY_SUB = 8'h0B;
   localparam logic [7:0] KEY_MUL = 8'h0C;
   localparam logic [7:0] KEY_AND = 8'h0D;
   localparam logic [7:0] KEY_CLR = 8'h0E;
   localparam logic [7:0] KEY_EQ  = 8'h0F;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_MUL = 2'd2,
      ALU_AND = 2'd3
   } alu_op_t;

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      EXEC    = 3'd2,
      WRITE   = 3'd3,
      SHOW    = 3'd4
   } state_t;

   function automatic logic is_digit(input logic [7:0] k);
      return k <= 8'h09;
   endfunction

   function automatic logic is_op_key(input logic [7:0] k);
      return (k >= KEY_ADD) && (k <= KEY_AND);
   endfunction

   function automatic alu_op_t key_to_op(input logic [7:0] k);
      alu_op_t r;
      case (k)
         KEY_SUB: r = ALU_SUB;
         KEY_MUL: r = ALU_MUL;
         KEY_AND: r = ALU_AND;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/key_event_sync.sv
// rtl/key_event_sync.sv - key_ready synchronizer, rising-edge event and code capture
//
// Purpose: turn the scanner's level-type key_ready into a single one-cycle event.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_code     scanner key code (stable by the time the event fires)
//   key_ready    level, asynchronous to clk
//   key_evt      one-cycle pulse per rising edge of the synchronized level
//   key_val      key_code captured together with key_evt
module key_event_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key_code,
   input  logic       key_ready,
   output logic       key_evt,
   output logic [7:0] key_val
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         prev    <= 1'b0;
         key_evt <= 1'b0;
         key_val <= 8'h00;
      end else begin
         sync1   <= key_ready;
         sync2   <= sync1;
         prev    <= sync2;
         key_evt <= sync2 & ~prev;
         // key_val is updated in the same edge that raises key_evt, so the
         // two are valid together for exactly one cycle.
         if (sync2 & ~prev) begin
            key_val <= key_code;
         end
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad calculator sequencer: operand entry, ALU drive, result write
//
// Purpose: decode key events into operand entry and operation selection, run one
// calculation through the external ALU and write the result to the register bank.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_code, key_ready   raw keypad scanner interface
//   alu_a, alu_b, alu_op  registered ALU operands and operation
//   alu_result            combinational ALU result (2*DATA_W wide)
//   rf_we, rf_waddr, rf_wdata  registered register-bank write port
//   disp_value            operand or result to display (decoded from state)
//   ovf                   last result did not fit in DATA_W (borrow for SUB)
//   busy                  high in EXEC/WRITE; key events are dropped then
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            key_code,
   input  logic                  key_ready,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [1:0]            alu_op,
   input  logic [2*DATA_W-1:0]   alu_result,
   output logic                  rf_we,
   output logic [ADDR_W-1:0]     rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [DATA_W-1:0]     disp_value,
   output logic                  ovf,
   output logic                  busy
);

   localparam int EXT_W = DATA_W + 4;
   localparam logic [EXT_W-1:0] MAX_VAL = {4'b0000, {DATA_W{1'b1}}};

   state_t              state;
   alu_op_t             op;
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic [DATA_W-1:0]   result;
   logic [ADDR_W-1:0]   wr_ptr;
   logic                key_evt;
   logic [7:0]          key_val;
   logic [EXT_W-1:0]    app_a;
   logic [EXT_W-1:0]    app_b;

   // Extra 4 bits hold op*10+d without wrapping so the overflow test is exact.
   function automatic logic [EXT_W-1:0] append_digit(input logic [DATA_W-1:0] v,
                                                     input logic [3:0] d);
      return ({4'b0000, v} * EXT_W'(10)) + {{DATA_W{1'b0}}, d};
   endfunction

   key_event_sync u_key_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_code  (key_code),
      .key_ready (key_ready),
      .key_evt   (key_evt),
      .key_val   (key_val)
   );

   assign app_a = append_digit(op_a, key_val[3:0]);
   assign app_b = append_digit(op_b, key_val[3:0]);
   assign busy  = (state == EXEC) || (state == WRITE);

   always_comb begin
      disp_value = result;
      case (state)
         ENTER_A: disp_value = op_a;
         ENTER_B: disp_value = op_b;
         default: disp_value = result;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ENTER_A;
         op       <= ALU_ADD;
         op_a     <= '0;
         op_b     <= '0;
         result   <= '0;
         wr_ptr   <= '0;
         ovf      <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= 2'd0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            ENTER_A, ENTER_B, SHOW: begin
               if (key_evt && (key_val <= KEY_EQ)) begin
                  ovf <= 1'b0;
                  if (is_digit(key_val)) begin
                     if (state == ENTER_A) begin
                        if (app_a <= MAX_VAL) begin
                           op_a <= app_a[DATA_W-1:0];
                        end
                     end else if (state == ENTER_B) begin
                        if (app_b <= MAX_VAL) begin
                           op_b <= app_b[DATA_W-1:0];
                        end
                     end else begin
                        // A digit after a result starts a fresh calculation.
                        op_a  <= {{(DATA_W-4){1'b0}}, key_val[3:0]};
                        op_b  <= '0;
                        state <= ENTER_A;
                     end
                  end else if (is_op_key(key_val)) begin
                     op <= key_to_op(key_val);
                     if (state != ENTER_B) begin
                        op_b <= '0;
                     end
                     // Chaining: the previous result becomes the new first operand.
                     if (state == SHOW) begin
                        op_a <= result;
                     end
                     state <= ENTER_B;
                  end else if (key_val == KEY_CLR) begin
                     op_a  <= '0;
                     op_b  <= '0;
                     op    <= ALU_ADD;
                     state <= ENTER_A;
                  end else if (state == ENTER_B) begin
                     // Only EQUALS remains; it launches the calculation.
                     alu_a  <= op_a;
                     alu_b  <= op_b;
                     alu_op <= op;
                     state  <= EXEC;
                  end
               end
            end
            EXEC: begin
               result   <= alu_result[DATA_W-1:0];
               ovf      <= |alu_result[2*DATA_W-1:DATA_W];
               rf_we    <= 1'b1;
               rf_waddr <= wr_ptr;
               rf_wdata <= alu_result[DATA_W-1:0];
               state    <= WRITE;
            end
            WRITE: begin
               wr_ptr <= wr_ptr + 1'b1;
               state  <= SHOW;
            end
            default: state <= ENTER_A;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [7:0]      key_code;
   logic            key_ready;
   logic [DW-1:0]   alu_a, alu_b;
   logic [1:0]      alu_op;
   logic [2*DW-1:0] alu_result;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic [DW-1:0]   disp_value;
   logic            ovf;
   logic            busy;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          ovf;
   } wr_t;

   typedef struct {
      int         a;
      logic [7:0] key;
      int         b;
      int         aop;
      int         data;
      int         ovf;
   } vec_t;

   wr_t           sb[$];
   wr_t           exp_w;
   vec_t          vecs[8];
   logic [AW-1:0] exp_ptr = '0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            n_writes = 0;

   always #5 clk = ~clk;

   calc_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .disp_value (disp_value),
      .ovf        (ovf),
      .busy       (busy)
   );

   // External ALU model
   always_comb begin
      case (alu_op)
         2'd0:    alu_result = {8'h00, alu_a} + {8'h00, alu_b};
         2'd1:    alu_result = {8'h00, alu_a} - {8'h00, alu_b};
         2'd2:    alu_result = {8'h00, alu_a} * {8'h00, alu_b};
         default: alu_result = {8'h00, alu_a & alu_b};
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Write-port scoreboard
   always @(negedge clk) begin
      if (rst_n && rf_we) begin
         n_writes++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: waddr %0d wdata %0d while none expected", rf_waddr, rf_wdata);
         end else begin
            exp_w = sb.pop_front();
            check("wr_addr", rf_waddr, exp_w.addr);
            check("wr_data", rf_wdata, exp_w.data);
            check("wr_ovf", ovf, exp_w.ovf);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_write(input int d, input int o);
      sb.push_back('{addr: exp_ptr, data: d[DW-1:0], ovf: o[0]});
      exp_ptr = exp_ptr + 1'b1;
   endtask

   task automatic press(input logic [7:0] code);
      @(negedge clk);
      key_code  = code;
      key_ready = 1'b1;
      repeat (4) @(negedge clk);
      key_ready = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic enter_num(input int n);
      if (n >= 100) press(8'(n / 100));
      if (n >= 10)  press(8'((n / 10) % 10));
      press(8'(n % 10));
   endtask

   task automatic calc(input vec_t v);
      press(KEY_CLR);
      enter_num(v.a);
      press(v.key);
      enter_num(v.b);
      expect_write(v.data, v.ovf);
      press(KEY_EQ);
      check("vec_alu_a", alu_a, v.a);
      check("vec_alu_b", alu_b, v.b);
      check("vec_alu_op", alu_op, v.aop);
      check("vec_disp", disp_value, v.data);
      check("vec_ovf", ovf, v.ovf);
   endtask

   initial begin
      int busy_cnt, we_cnt, busy_before_we, wcount;
      bit seen;

      vecs[0] = '{a: 12,  key: KEY_ADD, b: 34,  aop: 0, data: 46,  ovf: 0};
      vecs[1] = '{a: 200, key: KEY_ADD, b: 100, aop: 0, data: 44,  ovf: 1};
      vecs[2] = '{a: 5,   key: KEY_SUB, b: 9,   aop: 1, data: 252, ovf: 1};
      vecs[3] = '{a: 9,   key: KEY_SUB, b: 5,   aop: 1, data: 4,   ovf: 0};
      vecs[4] = '{a: 16,  key: KEY_MUL, b: 16,  aop: 2, data: 0,   ovf: 1};
      vecs[5] = '{a: 15,  key: KEY_MUL, b: 17,  aop: 2, data: 255, ovf: 0};
      vecs[6] = '{a: 240, key: KEY_AND, b: 60,  aop: 3, data: 48,  ovf: 0};
      vecs[7] = '{a: 255, key: KEY_AND, b: 255, aop: 3, data: 255, ovf: 0};

      rst_n     = 1'b0;
      key_code  = 8'h00;
      key_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rf_we", rf_we, 0);
      check("rst_rf_waddr", rf_waddr, 0);
      check("rst_rf_wdata", rf_wdata, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_disp", disp_value, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 12 + 3 with EQUALS timing observed cycle by cycle
      press(8'd1);
      press(8'd2);
      check("entry_disp_12", disp_value, 12);
      press(KEY_ADD);
      press(8'd3);
      check("entry_disp_b3", disp_value, 3);
      expect_write(15, 0);
      @(negedge clk);
      key_code  = KEY_EQ;
      key_ready = 1'b1;
      busy_cnt = 0;
      we_cnt = 0;
      busy_before_we = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 3) key_ready = 1'b0;
         if (busy) busy_cnt++;
         if (rf_we) we_cnt++;
         if (busy && !rf_we && we_cnt == 0) busy_before_we++;
      end
      check("eq_busy_cycles", busy_cnt, 2);
      check("eq_we_cycles", we_cnt, 1);
      check("eq_exec_before_write", busy_before_we, 1);
      check("first_alu_a", alu_a, 12);
      check("first_alu_b", alu_b, 3);
      check("first_alu_op", alu_op, 0);
      check("first_disp", disp_value, 15);
      check("first_ovf", ovf, 0);

      // Operand saturation, MUL overflow, then chaining with SUB
      press(KEY_CLR);
      press(8'd2);
      press(8'd5);
      press(8'd5);
      press(8'd9);
      check("digit_ignored_255", disp_value, 255);
      press(KEY_MUL);
      press(8'd2);
      expect_write(8'hFE, 1);
      press(KEY_EQ);
      check("mul_ovf", ovf, 1);
      check("mul_disp", disp_value, 8'hFE);
      press(KEY_SUB);
      check("chain_ovf_cleared", ovf, 0);
      press(8'd3);
      expect_write(251, 0);
      press(KEY_EQ);
      check("chain_alu_a", alu_a, 254);
      check("chain_disp", disp_value, 251);

      // Table of calculations; address wraps 7 -> 0 along the way
      foreach (vecs[i]) calc(vecs[i]);

      // Long hold produces a single digit
      press(KEY_CLR);
      @(negedge clk);
      key_code  = 8'd5;
      key_ready = 1'b1;
      repeat (10000) @(negedge clk);
      key_ready = 1'b0;
      repeat (8) @(negedge clk);
      check("hold_one_digit", disp_value, 5);

      // Second key pulse lands while the sequencer is in WRITE
      press(KEY_ADD);
      press(8'd1);
      expect_write(6, 0);
      @(negedge clk);
      key_code  = KEY_EQ;
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      @(negedge clk);
      key_ready = 1'b1;
      @(negedge clk);
      key_code  = 8'd7;
      repeat (3) @(negedge clk);
      key_ready = 1'b0;
      repeat (10) @(negedge clk);
      check("busy_key_dropped", disp_value, 6);
      check("busy_key_idle", busy, 0);

      // CLEAR cancels a pending calculation; EQUALS in ENTER_A does nothing
      wcount = n_writes;
      press(KEY_CLR);
      press(8'd4);
      press(KEY_ADD);
      press(8'd6);
      press(KEY_CLR);
      press(KEY_EQ);
      check("clear_no_write", n_writes, wcount);
      check("clear_disp", disp_value, 0);
      check("clear_busy", busy, 0);

      // Asynchronous reset in EXEC
      press(8'd1);
      press(KEY_ADD);
      press(8'd2);
      wcount = n_writes;
      @(negedge clk);
      key_code  = KEY_EQ;
      key_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      check("exec_reached", seen, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rf_we", rf_we, 0);
      check("arst_alu_a", alu_a, 0);
      check("arst_alu_b", alu_b, 0);
      check("arst_alu_op", alu_op, 0);
      check("arst_waddr", rf_waddr, 0);
      check("arst_wdata", rf_wdata, 0);
      check("arst_disp", disp_value, 0);
      check("arst_ovf", ovf, 0);
      check("arst_busy", busy, 0);
      key_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("arst_no_write", n_writes, wcount);

      // Write pointer restarts from 0 after reset
      exp_ptr = '0;
      press(8'd7);
      press(KEY_SUB);
      press(8'd2);
      expect_write(5, 0);
      press(KEY_EQ);
      check("post_reset_disp", disp_value, 5);

      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
